// File: rtl/ffd_bist_driver.sv
// Purpose: LFSR stimulus generator and response checker for a single D flip-flop under test.
// Latency: each vector is checked two edges after it is driven; done rises NUM_VECTORS+1 edges after start.
// Backpressure: none; start is ignored while busy and dut_q is assumed synchronous to clk.
module ffd_bist_driver #(
    parameter int         NUM_VECTORS = 10,
    parameter logic [7:0] LFSR_SEED   = 8'hA5,
    parameter int         CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dut_q,
    output logic             dut_d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] NV = CNT_W'(NUM_VECTORS);

    state_t           state, state_nxt;
    logic [7:0]       lfsr, lfsr_nxt;
    logic [CNT_W-1:0] issued, issued_nxt;
    logic [CNT_W-1:0] vec_nxt, err_nxt;
    logic             d_nxt;
    logic             d_vld, d_vld_nxt;   // dut_d currently carries a real vector
    logic             exp_bit, exp_nxt;   // value the flip-flop should present at the next check
    logic             chk_v, chk_v_nxt;
    logic             done_nxt, pass_nxt;

    // Fibonacci right-shift LFSR step; output bit is v[0].
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[4], v[7:1]};
    endfunction

    // Register all state; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lfsr      <= LFSR_SEED;
            issued    <= '0;
            dut_d     <= 1'b0;
            d_vld     <= 1'b0;
            exp_bit   <= 1'b0;
            chk_v     <= 1'b0;
            vec_count <= '0;
            err_count <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state     <= state_nxt;
            lfsr      <= lfsr_nxt;
            issued    <= issued_nxt;
            dut_d     <= d_nxt;
            d_vld     <= d_vld_nxt;
            exp_bit   <= exp_nxt;
            chk_v     <= chk_v_nxt;
            vec_count <= vec_nxt;
            err_count <= err_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
        end
    end

    // Next-state: stimulus issue, two-stage check pipeline and completion.
    always_comb begin
        state_nxt  = state;
        lfsr_nxt   = lfsr;
        issued_nxt = issued;
        d_nxt      = dut_d;
        d_vld_nxt  = d_vld;
        exp_nxt    = exp_bit;
        chk_v_nxt  = chk_v;
        vec_nxt    = vec_count;
        err_nxt    = err_count;
        done_nxt   = done;
        pass_nxt   = pass;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    // First vector comes straight from the seed so the LFSR needs no warm-up edge.
                    state_nxt  = RUN;
                    d_nxt      = LFSR_SEED[0];
                    lfsr_nxt   = lfsr_step(LFSR_SEED);
                    issued_nxt = CNT_W'(1);
                    d_vld_nxt  = 1'b1;
                    exp_nxt    = 1'b0;
                    chk_v_nxt  = 1'b0;
                    vec_nxt    = '0;
                    err_nxt    = '0;
                    done_nxt   = 1'b0;
                    pass_nxt   = 1'b0;
                end
            end
            RUN: begin
                if (issued < NV) begin
                    d_nxt      = lfsr[0];
                    lfsr_nxt   = lfsr_step(lfsr);
                    issued_nxt = issued + 1'b1;
                    d_vld_nxt  = 1'b1;
                end else begin
                    d_nxt     = 1'b0;
                    d_vld_nxt = 1'b0;
                    state_nxt = DRAIN;
                end
            end
            default: ;
        endcase

        if (state == RUN || state == DRAIN) begin
            // exp lags dut_d by one edge, matching the flip-flop's own capture delay.
            exp_nxt   = dut_d;
            chk_v_nxt = d_vld;
            if (chk_v) begin
                vec_nxt = vec_count + 1'b1;
                if (dut_q != exp_bit && err_count != '1)
                    err_nxt = err_count + 1'b1;
                if (vec_nxt == NV) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_nxt == '0);
                end
            end
        end
    end

    assign busy = (state == RUN) || (state == DRAIN);

endmodule

// File: tb/tb_ffd_bist_driver.sv
// Purpose: self-checking bench for ffd_bist_driver with several emulated flip-flop faults.
// Latency: checks done timing, dut_d sequence and final counters per run.
// Backpressure: n/a.
module tb_ffd_bist_driver;

    logic clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    logic       rst_n, start;
    logic [2:0] mode;
    logic       rnd_q;

    // Default instance
    logic       dut_q, dut_d, busy, done, pass;
    logic [7:0] vec_count, err_count;
    logic       ffq;

    // Saturation instances, both fed by an inverting flip-flop
    logic       d1, busy1, done1, pass1, ff1;
    logic [8:0] vc1, ec1;
    logic       d2, busy2, done2, pass2, ff2;
    logic [7:0] vc2, ec2;

    always_ff @(posedge clk_tb) begin
        ffq <= dut_d;
        ff1 <= d1;
        ff2 <= d2;
    end

    // Emulated device under test: 0 good FF, 1 stuck-0, 2 stuck-1, 3 missing reg, 4 inverted, 5 random
    always_comb begin
        dut_q = ffq;
        case (mode)
            3'd1:    dut_q = 1'b0;
            3'd2:    dut_q = 1'b1;
            3'd3:    dut_q = dut_d;
            3'd4:    dut_q = ~ffq;
            3'd5:    dut_q = rnd_q;
            default: dut_q = ffq;
        endcase
    end

    ffd_bist_driver u_dut0 (
        .clk(clk_tb), .rst_n(rst_n), .start(start), .dut_q(dut_q), .dut_d(dut_d),
        .busy(busy), .done(done), .pass(pass), .vec_count(vec_count), .err_count(err_count)
    );

    ffd_bist_driver #(.NUM_VECTORS(300), .LFSR_SEED(8'hA5), .CNT_W(9)) u_dut1 (
        .clk(clk_tb), .rst_n(rst_n), .start(start), .dut_q(~ff1), .dut_d(d1),
        .busy(busy1), .done(done1), .pass(pass1), .vec_count(vc1), .err_count(ec1)
    );

    ffd_bist_driver #(.NUM_VECTORS(255), .LFSR_SEED(8'hA5), .CNT_W(8)) u_dut2 (
        .clk(clk_tb), .rst_n(rst_n), .start(start), .dut_q(~ff2), .dut_d(d2),
        .busy(busy2), .done(done2), .pass(pass2), .vec_count(vc2), .err_count(ec2)
    );

    int errors = 0;
    int checks = 0;
    int v[0:31];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference stream: v[k] is the k-th bit sent, v[n+1] is the idle 0 after the last vector.
    function automatic void gen(input int n);
        int l;
        int fb;
        l = 8'hA5;
        for (int k = 1; k <= n; k++) begin
            v[k] = l & 1;
            fb   = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 4)) & 1;
            l    = (fb << 7) | (l >> 1);
        end
        v[n+1] = 0;
    endfunction

    // One run of the default instance; called at a negedge, returns at a negedge.
    task automatic run_one(input int m, input string tag, input int poke);
        int n = 10;
        int rq[0:31];
        int bad, busy_bad, done_at, exp_err, q;
        mode = m[2:0];
        gen(n);
        start = 1'b1;
        @(negedge clk_tb);
        start = 1'b0;
        chk({tag, "_busy_e0"}, busy, 1);
        chk({tag, "_done_e0"}, done, 0);
        chk({tag, "_pass_e0"}, pass, 0);
        chk({tag, "_vec_e0"}, vec_count, 0);
        chk({tag, "_err_e0"}, err_count, 0);
        bad      = (dut_d !== v[1][0]) ? 1 : 0;
        busy_bad = 0;
        done_at  = 0;
        rnd_q = 1'($urandom_range(0, 1));
        rq[1] = rnd_q;
        for (int j = 1; j <= n + 5 && done_at == 0; j++) begin
            if (j == poke) start = 1'b1;
            @(negedge clk_tb);
            start = 1'b0;
            if (j <= n - 1) bad += (dut_d !== v[j+1][0]) ? 1 : 0;
            else if (j == n) bad += (dut_d !== 1'b0) ? 1 : 0;
            if (done === 1'b1) done_at = j;
            else if (busy !== 1'b1) busy_bad++;
            rnd_q = 1'($urandom_range(0, 1));
            if (j + 1 <= 31) rq[j+1] = rnd_q;
        end
        exp_err = 0;
        for (int k = 1; k <= n; k++) begin
            case (m)
                1:       q = 0;
                2:       q = 1;
                3:       q = v[k+1];
                4:       q = 1 - v[k];
                5:       q = rq[k+1];
                default: q = v[k];
            endcase
            if (q != v[k]) exp_err++;
        end
        chk({tag, "_dseq_bad"}, bad, 0);
        chk({tag, "_busy_bad"}, busy_bad, 0);
        chk({tag, "_done_at"}, done_at, n + 1);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_vec"}, vec_count, n);
        chk({tag, "_err"}, err_count, exp_err);
        chk({tag, "_pass"}, pass, (exp_err == 0) ? 1 : 0);
    endtask

    initial begin
        int t1, t2;
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 3'd0;
        rnd_q = 1'b0;
        repeat (2) @(negedge clk_tb);
        chk("rst_dut_d", dut_d, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_vec", vec_count, 0);
        chk("rst_err", err_count, 0);
        rst_n = 1'b1;
        @(negedge clk_tb);

        // Saturation / long runs on the wide and 8-bit instances
        start = 1'b1;
        @(negedge clk_tb);
        start = 1'b0;
        t1 = 0;
        t2 = 0;
        for (int j = 1; j <= 400 && (t1 == 0 || t2 == 0); j++) begin
            @(negedge clk_tb);
            if (t1 == 0 && done1 === 1'b1) t1 = j;
            if (t2 == 0 && done2 === 1'b1) t2 = j;
        end
        chk("sat300_done_at", t1, 301);
        chk("sat300_err", ec1, 300);
        chk("sat300_vec", vc1, 300);
        chk("sat300_pass", pass1, 0);
        chk("sat255_done_at", t2, 256);
        chk("sat255_err", ec2, 255);
        chk("sat255_vec", vc2, 255);
        chk("sat255_pass", pass2, 0);

        run_one(0, "loop", 0);
        run_one(1, "stuck0", 0);
        run_one(2, "stuck1", 0);
        run_one(3, "noreg", 0);
        run_one(4, "invert", 0);
        run_one(0, "poke_run", 3);
        run_one(0, "restart_done", 0);

        // Asynchronous reset in the middle of a run
        mode  = 3'd0;
        start = 1'b1;
        @(negedge clk_tb);
        start = 1'b0;
        repeat (4) @(negedge clk_tb);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_dut_d", dut_d, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_pass", pass, 0);
        chk("mid_rst_vec", vec_count, 0);
        chk("mid_rst_err", err_count, 0);
        #1 rst_n = 1'b1;
        @(negedge clk_tb);
        run_one(0, "after_rst", 0);

        // Random responses from the emulated device
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk_tb);
            run_one(5, "rand", 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ffd_bist_driver.md
Name: ffd_bist_driver

Overview:
- Hardware stimulus generator and response checker for a single-bit positive-edge D flip-flop under test.
- An 8-bit LFSR produces a pseudo-random data stream on dut_d. The block samples the flip-flop's Q on dut_q, compares it against the expected value, and counts vectors and mismatches.
- The block is used as the self-checking driver on the board or in the sequential-circuits lab, in place of a simulation-only bench.

Parameters:
- NUM_VECTORS, 10, number of data bits driven and checked per run (1 to 2^CNT_W-1).
- LFSR_SEED, 8'hA5, LFSR load value at start (nonzero).
- CNT_W, 8, width of vec_count and err_count.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin a run; sampled only in IDLE or DONE.
- dut_q, input, 1, Q output of the flip-flop under test.
- dut_d, output, 1, registered data driven to the D input of the flip-flop under test.
- busy, output, 1, high in RUN and DRAIN.
- done, output, 1, high in DONE until the next start or reset.
- pass, output, 1, high in DONE when err_count == 0.
- vec_count, output, CNT_W, number of compares performed.
- err_count, output, CNT_W, number of mismatches; saturates at all-ones.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - dut_d, busy, done, pass = 0; vec_count, err_count = 0.
  - lfsr = LFSR_SEED; internal exp/chk_v/issued = 0.
  - Reset mid-run aborts immediately. There is no resume.
- LFSR: Fibonacci, right shift.
  - Output bit lfsr[0].
  - fb = lfsr[0]^lfsr[2]^lfsr[3]^lfsr[4].
  - next = {fb, lfsr[7:1]}.
  - With seed A5 the first 10 output bits are 1,0,1,0,0,1,0,1,0,1.
- All state changes occur on the rising edge of clk.
- IDLE / DONE with start = 1, at edge e0:
  - state <= RUN.
  - dut_d <= lfsr_seed[0]; lfsr <= next(seed); issued <= 1.
  - vec_count, err_count, done, pass <= 0.
- RUN, at each edge:
  - If issued < NUM_VECTORS: dut_d <= lfsr[0], advance lfsr, issued++.
  - Otherwise: dut_d <= 0 and state <= DRAIN.
- Check pipeline (RUN and DRAIN):
  - At every edge: exp <= dut_d and chk_v <= (dut_d currently holds a vector).
  - When chk_v = 1 at an edge: vec_count++; if dut_q != exp, err_count++ (saturating).
  - Effect: the vector driven after edge k is captured by the flip-flop at edge k+1 and checked at edge k+2.
- DRAIN: when the last compare fires (vec_count reaches NUM_VECTORS), at the same edge:
  - state <= DONE, done <= 1.
  - pass <= (final err_count == 0), including the mismatch counted at that edge.
- Timing:
  - busy rises at e0 and falls at e(NUM_VECTORS+1).
  - done rises at e(NUM_VECTORS+1).
- start while busy is ignored. start held high in DONE restarts at the next edge.
- dut_q is treated as synchronous to clk. It is not synchronized internally.

Test Plan:
1. Loopback: dut_q = Q of a positive-edge D flip-flop fed by dut_d, defaults, one-cycle start pulse -> dut_d sequence 1010010101; done rises 11 cycles after the start edge; vec_count=10, err_count=0, pass=1.
2. Stuck-at: dut_q tied 0, defaults -> done after 11 cycles; vec_count=10, err_count=5, pass=0. Repeat with dut_q tied 1 -> err_count=5.
3. Missing register: dut_q wired directly to dut_d -> each vector is compared against the next bit (the final one against 0) -> err_count=9, pass=0.
4. Reset mid-run: start, drop rst_n for 2 ns at cycle 4 -> all outputs 0 asynchronously, state IDLE; a new start with loopback reproduces scenario 1 exactly.
5. Control edge cases: start pulsed again during RUN -> ignored, results as scenario 1. start asserted in DONE -> done and pass clear at the next edge, and the identical sequence reruns.
6. Saturation: NUM_VECTORS=300, CNT_W=9, dut_q = ~Q of the flip-flop -> err_count=300, vec_count=300. With CNT_W=8 and NUM_VECTORS=255, dut_q inverted -> err_count=255.
